sev_seg_scanner: RTL and testbench
==================================

Name: sev_seg_scanner

Overview:
Parametrised multiplexed seven-segment scanner, the next generation of the fixed 8-digit display driver. It scans NUM_DIGITS hex digits at one digit per sclk_1ms tick. It adds frame-synchronous input capture (no tearing), per-digit decimal points, leading-zero blanking, per-digit blink, and selectable output polarity. It sits between the ATM datapath (balance/PIN display value) and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
ACTIVE_LOW, 1, 1 = segments, DP and digit enables are active-low; 0 = active-high
BLINK_HALF_PERIOD, 250, sclk_1ms ticks per blink on/off phase (>=1)

Ports:
sclk_1ms  input  1  scan clock, 1 kHz tick
rst  input  1  reset, asynchronous, active-high
data  input  4*NUM_DIGITS  hex digits; digit i = data[4i+3:4i], digit 0 = least significant
dp_in  input  NUM_DIGITS  decimal point request per digit
blink_en  input  NUM_DIGITS  per-digit blink enable
blank_lz  input  1  leading-zero blanking enable
LED_Out  output  7  segment pattern {g,f,e,d,c,b,a}
LED_DP  output  1  decimal point segment
LED_Control  output  NUM_DIGITS  one-hot digit enable (one-cold when ACTIVE_LOW)
frame_done  output  1  one-tick pulse while the last digit is driven

Behaviour:
- Reset, asynchronous, immediate: sel=0, shadow registers=0, blink counter=0, blink phase=ON. LED_Out/LED_DP = all segments off, LED_Control = all digits disabled, frame_done=0. Off/disabled means all-1s if ACTIVE_LOW, else all-0s.
- Scan: sel counts 0..NUM_DIGITS-1, then wraps to 0. All outputs are registered. At the edge where sel==k, the outputs are updated to drive digit k and sel advances. The first edge after reset release drives digit 0.
- Frame capture: at each edge with sel==0, shadow_data/shadow_dp/shadow_blink/shadow_lz capture data/dp_in/blink_en/blank_lz. Digit 0's outputs on that same edge use the incoming values directly. Digits 1..N-1 use the shadow only. Input changes mid-frame are invisible until the next frame.
- Leading-zero blanking (shadow_lz=1): walk from digit N-1 downward. A digit is blanked while its value==0 and its dp bit==0. The first nonzero digit, or the first digit with dp set, ends the run. Digit 0 is never blanked. A blanked digit drives all segments off and DP off, but its LED_Control enable still asserts.
- Blink: the counter runs 0..BLINK_HALF_PERIOD-1 on every tick. On wrap, the phase toggles. The counter is independent of the frame. During the OFF phase, digits with shadow_blink set have LED_Control disabled, segments off and DP off.
- Decode: hex 0-F to standard segments, active-low values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. When ACTIVE_LOW=0, every value is inverted.
- frame_done = 1 exactly on the tick when digit NUM_DIGITS-1 is driven, otherwise 0.
- Reset mid-frame: all outputs go to the off state immediately. Scanning restarts at digit 0 with a fresh capture.
- Widths: sel is $clog2(NUM_DIGITS) bits. The blink counter is $clog2(BLINK_HALF_PERIOD+1) bits. sel never exceeds NUM_DIGITS-1, including for non-power-of-2 NUM_DIGITS.

Decomposition:
- Package sev_seg_pkg: 16-entry hex-to-segment constant table (active-low form), SEG_OFF constant, and a polarity-apply function.
- One sub-module, sev_seg_hex_decoder: combinational 4-bit to 7-segment decoder using the package table, with an ACTIVE_LOW parameter.
- Scan counter, shadow capture, LZ mask and blink timer remain in sev_seg_scanner.

Test Plan:
- Reset and scan order (N=8, ACTIVE_LOW=1): release rst -> LED_Control = FE, FD, FB, ... 7F, FE on successive ticks; frame_done high only on the 7F tick.
- LZ blanking: data=0x00000105, blank_lz=1 -> digits 7..3 show LED_Out=1111111 with enable asserted; digit2=1111001, digit1=1000000, digit0=0010010.
- DP stops LZ: data=0x00000005, dp_in=8'h02, blank_lz=1 -> digit1 shows 1000000 with LED_DP=0; digit0=0010010; digits 7..2 blank.
- Tear-free capture: change data from 0x11111111 to 0x22222222 while digit 3 is driven -> digits 3..7 still show 1; next frame shows 2 on all digits.
- Blink: BLINK_HALF_PERIOD=4, blink_en=8'h01 -> digit0's enable is absent for 4 ticks after each 4-tick ON phase; other digits unaffected.
- Odd width and polarity: N=6, ACTIVE_LOW=0, data=0xABCDEF, async rst asserted mid-frame -> outputs go to 0 immediately; after release sel cycles 0..5 only; digit5 LED_Out=1110111 (A inverted).

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex segment table (active-low form)
// and the polarity helper used wherever a segment pattern reaches the pins.
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Packed {g,f,e,d,c,b,a} patterns, index 15 (F) first so HEX_SEG_AL[n] is digit n.
    localparam logic [15:0][6:0] HEX_SEG_AL = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic seg_t seg_polarity(input seg_t seg_al, input logic active_low);
        return active_low ? seg_al : ~seg_al;
    endfunction

endpackage

// File: rtl/sev_seg_hex_decoder.sv
// Combinational hex digit to seven-segment decoder with selectable output polarity.
module sev_seg_hex_decoder
    import sev_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = seg_polarity(HEX_SEG_AL[hex], ACTIVE_LOW);

endmodule

// File: rtl/sev_seg_scanner.sv
// Multiplexed seven-segment scanner: one digit per tick, frame-synchronous capture,
// decimal points, leading-zero blanking, per-digit blink and selectable polarity.
module sev_seg_scanner
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS        = 8,
    parameter int ACTIVE_LOW        = 1,
    parameter int BLINK_HALF_PERIOD = 250
) (
    input  logic                    sclk_1ms,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              LED_Out,
    output logic                    LED_DP,
    output logic [NUM_DIGITS-1:0]   LED_Control,
    output logic                    frame_done
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_PERIOD - 1);
    localparam bit AL = (ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF_POL = seg_polarity(SEG_OFF, AL);
    localparam logic [NUM_DIGITS-1:0] CTRL_XOR = {NUM_DIGITS{AL}};

    logic [SEL_W-1:0]               sel;
    logic [NUM_DIGITS-1:0][3:0]     shadow_data;
    logic [NUM_DIGITS-1:0]          shadow_dp;
    logic [NUM_DIGITS-1:0]          shadow_blink;
    logic                           shadow_lz;
    logic [CNT_W-1:0]               blink_cnt;
    logic                           blink_on;

    logic [NUM_DIGITS-1:0]          lz_mask;
    logic [3:0]                     cur_hex;
    logic                           cur_dp;
    logic                           cur_blink;
    logic                           blink_off;
    logic                           seg_kill;
    logic                           dp_on;
    logic [NUM_DIGITS-1:0]          onehot;
    logic [6:0]                     dec_seg;

    // Leading-zero run from the top digit; digit 0 is left out so it always shows.
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = shadow_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run && (shadow_data[i] == 4'h0) && !shadow_dp[i])
                lz_mask[i] = 1'b1;
            else
                run = 1'b0;
        end
    end

    // Digit 0 is driven on the capture edge itself, so it reads the live inputs.
    always_comb begin
        cur_hex   = shadow_data[sel];
        cur_dp    = shadow_dp[sel];
        cur_blink = shadow_blink[sel];
        if (sel == '0) begin
            cur_hex   = data[3:0];
            cur_dp    = dp_in[0];
            cur_blink = blink_en[0];
        end
        blink_off = !blink_on && cur_blink;
        seg_kill  = lz_mask[sel] || blink_off;
        dp_on     = cur_dp && !seg_kill;
        onehot    = '0;
        if (!blink_off)
            onehot[sel] = 1'b1;
    end

    sev_seg_hex_decoder #(
        .ACTIVE_LOW (AL)
    ) u_dec (
        .hex (cur_hex),
        .seg (dec_seg)
    );

    always_ff @(posedge sclk_1ms or posedge rst) begin
        if (rst) begin
            sel          <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blink <= '0;
            shadow_lz    <= 1'b0;
        end else begin
            sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            if (sel == '0) begin
                shadow_data  <= data;
                shadow_dp    <= dp_in;
                shadow_blink <= blink_en;
                shadow_lz    <= blank_lz;
            end
        end
    end

    // Blink timer free-runs independently of the scan frame.
    always_ff @(posedge sclk_1ms or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge sclk_1ms or posedge rst) begin
        if (rst) begin
            LED_Out     <= SEG_OFF_POL;
            LED_DP      <= AL;
            LED_Control <= CTRL_XOR;
            frame_done  <= 1'b0;
        end else begin
            LED_Out     <= seg_kill ? SEG_OFF_POL : dec_seg;
            LED_DP      <= dp_on ^ AL;
            LED_Control <= onehot ^ CTRL_XOR;
            frame_done  <= (sel == SEL_LAST);
        end
    end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Randomized bench for sev_seg_scanner: an 8-digit active-low and a 6-digit
// active-high instance checked every tick against a frame-level reference model.
module tb_sev_seg_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] data8;
    logic [7:0]  dp8, bl8;
    logic        lz8;
    logic [6:0]  seg8;
    logic        ledp8, fd8;
    logic [7:0]  ctrl8;

    logic [23:0] data6;
    logic [5:0]  dp6, bl6;
    logic        lz6;
    logic [6:0]  seg6;
    logic        ledp6, fd6;
    logic [5:0]  ctrl6;

    sev_seg_scanner #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .BLINK_HALF_PERIOD(4)) dut8 (
        .sclk_1ms(clk), .rst(rst), .data(data8), .dp_in(dp8), .blink_en(bl8),
        .blank_lz(lz8), .LED_Out(seg8), .LED_DP(ledp8), .LED_Control(ctrl8),
        .frame_done(fd8)
    );

    sev_seg_scanner #(.NUM_DIGITS(6), .ACTIVE_LOW(0), .BLINK_HALF_PERIOD(3)) dut6 (
        .sclk_1ms(clk), .rst(rst), .data(data6), .dp_in(dp6), .blink_en(bl6),
        .blank_lz(lz6), .LED_Out(seg6), .LED_DP(ledp6), .LED_Control(ctrl6),
        .frame_done(fd6)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] ctrl;
        logic        fd;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    int t8, t6;
    logic [63:0] snap8_data, snap6_data;
    logic [15:0] snap8_dp, snap8_bl, snap6_dp, snap6_bl;
    logic        snap8_lz, snap6_lz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Tick t after reset drives digit t mod n; blink is ON for the first hp ticks, OFF the next hp.
    function automatic exp_t model(input int n, input bit al, input int hp, input int t,
                                   input logic [63:0] sd, input logic [15:0] sdp,
                                   input logic [15:0] sbl, input bit slz);
        exp_t e;
        int d;
        bit on, blank, boff, dpon;
        logic [6:0]  s_al;
        logic [15:0] ch, mask;
        d     = t % n;
        on    = ((t / hp) % 2) == 0;
        blank = slz && (d != 0) && ((sd >> (4 * d)) == 64'h0) && ((sdp >> d) == 16'h0);
        boff  = !on && sbl[d];
        s_al  = (blank || boff) ? 7'h7f : seg_tab[sd[4*d +: 4]];
        dpon  = sdp[d] && !blank && !boff;
        ch    = boff ? 16'h0 : (16'h1 << d);
        mask  = (16'h1 << n) - 16'h1;
        e.seg  = al ? s_al : ~s_al;
        e.dp   = al ? !dpon : dpon;
        e.ctrl = al ? (~ch & mask) : ch;
        e.fd   = (d == n - 1);
        return e;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_seg8"},  32'(seg8),  32'h7f);
        check_eq({tag, "_dp8"},   32'(ledp8), 32'h1);
        check_eq({tag, "_ctrl8"}, 32'(ctrl8), 32'hff);
        check_eq({tag, "_fd8"},   32'(fd8),   32'h0);
        check_eq({tag, "_seg6"},  32'(seg6),  32'h0);
        check_eq({tag, "_dp6"},   32'(ledp6), 32'h0);
        check_eq({tag, "_ctrl6"}, 32'(ctrl6), 32'h0);
        check_eq({tag, "_fd6"},   32'(fd6),   32'h0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        exp_t e8, e6;
        if (t8 % 8 == 0) begin
            snap8_data = 64'(data8); snap8_dp = 16'(dp8); snap8_bl = 16'(bl8); snap8_lz = lz8;
        end
        if (t6 % 6 == 0) begin
            snap6_data = 64'(data6); snap6_dp = 16'(dp6); snap6_bl = 16'(bl6); snap6_lz = lz6;
        end
        e8 = model(8, 1'b1, 4, t8, snap8_data, snap8_dp, snap8_bl, snap8_lz);
        e6 = model(6, 1'b0, 3, t6, snap6_data, snap6_dp, snap6_bl, snap6_lz);
        @(posedge clk);
        #1;
        check_eq("seg8",  32'(seg8),  32'(e8.seg));
        check_eq("dp8",   32'(ledp8), 32'(e8.dp));
        check_eq("ctrl8", 32'(ctrl8), 32'(e8.ctrl));
        check_eq("fd8",   32'(fd8),   32'(e8.fd));
        check_eq("seg6",  32'(seg6),  32'(e6.seg));
        check_eq("dp6",   32'(ledp6), 32'(e6.dp));
        check_eq("ctrl6", 32'(ctrl6), 32'(e6.ctrl));
        check_eq("fd6",   32'(fd6),   32'(e6.fd));
        t8++;
        t6++;
        @(negedge clk);
    endtask

    task automatic reset_mid();
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        t8  = 0;
        t6  = 0;
    endtask

    // Low digits random (often zero), upper digits zero so leading-zero runs occur.
    function automatic logic [63:0] rand_digits(input int n);
        logic [63:0] r;
        int k;
        r = 64'h0;
        k = $urandom_range(0, n);
        for (int i = 0; i < k; i++)
            if ($urandom_range(0, 2) != 0)
                r[4*i +: 4] = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic randomize_inputs();
        logic [63:0] r;
        r     = rand_digits(8);
        data8 = r[31:0];
        r     = rand_digits(6);
        data6 = r[23:0];
        dp8   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
        dp6   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
        bl8   = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h0;
        bl6   = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'h0;
        lz8   = 1'($urandom_range(0, 1));
        lz6   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        data8 = 32'h0; dp8 = 8'h0; bl8 = 8'h0; lz8 = 1'b0;
        data6 = 24'h0; dp6 = 6'h0; bl6 = 6'h0; lz6 = 1'b0;
        t8 = 0; t6 = 0;
        repeat (2) @(negedge clk);
        check_reset("init");
        rst = 1'b0;

        data8 = 32'h00000105; lz8 = 1'b1; data6 = 24'hABCDEF;
        repeat (16) step();
        data8 = 32'h00000005; dp8 = 8'h02;
        repeat (16) step();
        dp8 = 8'h0; lz8 = 1'b0; data8 = 32'h11111111;
        repeat (11) step();
        data8 = 32'h22222222;
        repeat (13) step();
        bl8 = 8'h01; bl6 = 6'h20;
        repeat (24) step();
        repeat (3) step();
        reset_mid();
        repeat (10) step();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                randomize_inputs();
            if ($urandom_range(0, 99) == 0)
                reset_mid();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
